// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU codes, datapath select values, FSM states and the control-vector type.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_LUI = 3'b100;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_RS     = 2'b11;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MDR = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_R  = 4'd2,
      S_WB_R   = 4'd3,
      S_EXE_I  = 4'd4,
      S_WB_I   = 4'd5,
      S_ADDR   = 4'd6,
      S_MEM_LD = 4'd7,
      S_MEM_ST = 4'd8,
      S_WB_LD  = 4'd9,
      S_BR     = 4'd10,
      S_JMP    = 4'd11,
      S_ERR    = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_wr;
      logic [1:0] pc_src;
      logic       ir_wr;
      logic       reg_wr;
      logic [1:0] reg_dst;
      logic [1:0] wb_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      logic [2:0] alu_op;
      logic       mem_wr;
      logic       instr_done;
      logic       err;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded IR fields and flags in, control vector out.
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       gtz;
   logic       pc_wr;
   logic [1:0] pc_src;
   logic       ir_wr;
   logic       reg_wr;
   logic [1:0] reg_dst;
   logic [1:0] wb_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_op;
   logic [2:0] alu_op;
   logic       mem_wr;
   logic       instr_done;
   logic       err;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, gtz,
      output pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wb_src, alu_src_a,
             alu_src_b, ext_op, alu_op, mem_wr, instr_done, err, state
   );

   modport slave (
      output op, funct, zero, gtz,
      input  pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wb_src, alu_src_a,
             alu_src_b, ext_op, alu_op, mem_wr, instr_done, err, state
   );
endinterface

// File: rtl/multicycle_ctrl_dec.sv
// Combinational Moore decoder: current state (+ op/funct, last-wait flag)
// to the full control vector. zero/gtz only matter for the branch write.
module multicycle_ctrl_dec
   import mips_defs::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       gtz,
   input  logic       mem_last,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.ir_wr     = 1'b1;
            ctrl.pc_wr     = 1'b1;
            ctrl.pc_src    = PCS_ALU;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
         end
         // Branch target is precomputed here so S_BR can use the ALU for the compare.
         S_ID: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.ext_op    = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         S_EXE_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            case (funct)
               FN_SUBU: ctrl.alu_op = ALU_SUB;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         S_WB_R: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.reg_dst    = RD_RD;
            ctrl.wb_src     = WB_ALU;
            ctrl.instr_done = 1'b1;
         end
         S_EXE_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ext_op    = (op == OP_ADDIU);
            case (op)
               OP_ORI:  ctrl.alu_op = ALU_OR;
               OP_LUI:  ctrl.alu_op = ALU_LUI;
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         S_WB_I: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.reg_dst    = RD_RT;
            ctrl.wb_src     = WB_ALU;
            ctrl.instr_done = 1'b1;
         end
         S_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ext_op    = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ST: begin
            ctrl.mem_wr     = 1'b1;
            ctrl.instr_done = mem_last;
         end
         S_WB_LD: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.reg_dst    = RD_RT;
            ctrl.wb_src     = WB_MDR;
            ctrl.instr_done = 1'b1;
         end
         S_BR: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_RT;
            ctrl.alu_op     = ALU_SUB;
            ctrl.pc_src     = PCS_ALUOUT;
            ctrl.instr_done = 1'b1;
            ctrl.pc_wr      = ((op == OP_BEQ) && zero) || ((op == OP_BGTZ) && gtz);
         end
         // jal links from PC, which already holds PC+4 after fetch.
         S_JMP: begin
            ctrl.pc_wr      = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.pc_src     = (op == OP_RTYPE) ? PCS_RS : PCS_JUMP;
            if (op == OP_JAL) begin
               ctrl.reg_wr  = 1'b1;
               ctrl.reg_dst = RD_RA;
               ctrl.wb_src  = WB_PC;
            end
         end
         S_ERR: ctrl.err = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, memory wait counter and
// next-state logic; the control vector comes from multicycle_ctrl_dec.
module multicycle_ctrl
   import mips_defs::*;
#(
   parameter int MEM_WAIT = 0
) (
   input logic              clk,
   input logic              reset,
   multicycle_ctrl_if.master bus
);

   state_t     state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       mem_last;
   ctrl_t      ctrl_raw;
   ctrl_t      ctrl_out;

   assign mem_last = (wcnt_q == 4'(MEM_WAIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IF;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            case (bus.op)
               OP_RTYPE: begin
                  if (bus.funct == FN_JR)
                     state_d = S_JMP;
                  else if (bus.funct == FN_ADDU || bus.funct == FN_SUBU || bus.funct == FN_SLT)
                     state_d = S_EXE_R;
                  else
                     state_d = S_ERR;
               end
               OP_J, OP_JAL:            state_d = S_JMP;
               OP_ADDIU, OP_ORI, OP_LUI: state_d = S_EXE_I;
               OP_LW, OP_SW:            state_d = S_ADDR;
               OP_BEQ, OP_BGTZ:         state_d = S_BR;
               default:                 state_d = S_ERR;
            endcase
         end
         S_EXE_R: state_d = S_WB_R;
         S_EXE_I: state_d = S_WB_I;
         S_ADDR:  state_d = (bus.op == OP_LW) ? S_MEM_LD : S_MEM_ST;
         // Memory states dwell MEM_WAIT+1 cycles; the counter is back at 0 on exit.
         S_MEM_LD, S_MEM_ST: begin
            if (mem_last) begin
               wcnt_d  = '0;
               state_d = (state_q == S_MEM_LD) ? S_WB_LD : S_IF;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         S_WB_R, S_WB_I, S_WB_LD, S_BR, S_JMP: state_d = S_IF;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   multicycle_ctrl_dec u_dec (
      .state    (state_q),
      .op       (bus.op),
      .funct    (bus.funct),
      .zero     (bus.zero),
      .gtz      (bus.gtz),
      .mem_last (mem_last),
      .ctrl     (ctrl_raw)
   );

   // Reset parks the FSM in S_IF, whose fetch enables must not fire until release.
   always_comb begin
      ctrl_out = ctrl_raw;
      if (reset) begin
         ctrl_out.pc_wr      = 1'b0;
         ctrl_out.ir_wr      = 1'b0;
         ctrl_out.reg_wr     = 1'b0;
         ctrl_out.mem_wr     = 1'b0;
         ctrl_out.instr_done = 1'b0;
         ctrl_out.err        = 1'b0;
      end
   end

   assign bus.pc_wr      = ctrl_out.pc_wr;
   assign bus.pc_src     = ctrl_out.pc_src;
   assign bus.ir_wr      = ctrl_out.ir_wr;
   assign bus.reg_wr     = ctrl_out.reg_wr;
   assign bus.reg_dst    = ctrl_out.reg_dst;
   assign bus.wb_src     = ctrl_out.wb_src;
   assign bus.alu_src_a  = ctrl_out.alu_src_a;
   assign bus.alu_src_b  = ctrl_out.alu_src_b;
   assign bus.ext_op     = ctrl_out.ext_op;
   assign bus.alu_op     = ctrl_out.alu_op;
   assign bus.mem_wr     = ctrl_out.mem_wr;
   assign bus.instr_done = ctrl_out.instr_done;
   assign bus.err        = ctrl_out.err;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state-sequence model plus a
// per-cycle output table, compared every cycle; two DUTs (MEM_WAIT 0 and 3).
module tb_multicycle_ctrl;
   import mips_defs::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, sel;
   logic [5:0] op, funct;
   logic       zero, gtz;

   multicycle_ctrl_if bus0 ();
   multicycle_ctrl_if bus1 ();

   multicycle_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0.master));
   multicycle_ctrl #(.MEM_WAIT(3)) dut1 (.clk(clk), .reset(rst1), .bus(bus1.master));

   assign bus0.op = op;  assign bus0.funct = funct;  assign bus0.zero = zero;  assign bus0.gtz = gtz;
   assign bus1.op = op;  assign bus1.funct = funct;  assign bus1.zero = zero;  assign bus1.gtz = gtz;

   // {pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wb_src, a, b, ext, alu_op, mem_wr, done, err, state}
   logic [22:0] v0, v1, act, exp_vec;
   assign v0 = {bus0.pc_wr, bus0.pc_src, bus0.ir_wr, bus0.reg_wr, bus0.reg_dst, bus0.wb_src,
                bus0.alu_src_a, bus0.alu_src_b, bus0.ext_op, bus0.alu_op, bus0.mem_wr,
                bus0.instr_done, bus0.err, bus0.state};
   assign v1 = {bus1.pc_wr, bus1.pc_src, bus1.ir_wr, bus1.reg_wr, bus1.reg_dst, bus1.wb_src,
                bus1.alu_src_a, bus1.alu_src_b, bus1.ext_op, bus1.alu_op, bus1.mem_wr,
                bus1.instr_done, bus1.err, bus1.state};
   assign act = sel ? v1 : v0;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_valid = 1'b0;
   int obs_cycles, obs_mem, obs_reg, obs_reg_cycle, obs_done, obs_pcwr;

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, a, e, $time);
      end
   endtask

   // Output table for one cycle, written straight from the per-state rules.
   function automatic logic [22:0] model(input logic [3:0] st, input logic [5:0] o,
                                         input logic [5:0] f, input logic z, input logic g,
                                         input logic last);
      logic pw, irw, rw, a, ext, mw, dn, er;
      logic [1:0] ps, rd, wb, b;
      logic [2:0] alu;
      {pw, irw, rw, a, ext, mw, dn, er} = '0;
      {ps, rd, wb, b} = '0;
      alu = 3'd0;
      case (st)
         4'd0:  begin irw = 1; pw = 1; b = 2'd1; end
         4'd1:  begin b = 2'd3; ext = 1; end
         4'd2:  begin a = 1; alu = (f == 6'b100011) ? 3'd1 : (f == 6'b101010) ? 3'd3 : 3'd0; end
         4'd3:  begin rw = 1; rd = 2'd1; dn = 1; end
         4'd4:  begin a = 1; b = 2'd2; ext = (o == 6'b001001);
                      alu = (o == 6'b001101) ? 3'd2 : (o == 6'b001111) ? 3'd4 : 3'd0; end
         4'd5:  begin rw = 1; dn = 1; end
         4'd6:  begin a = 1; b = 2'd2; ext = 1; end
         4'd8:  begin mw = 1; dn = last; end
         4'd9:  begin rw = 1; wb = 2'd1; dn = 1; end
         4'd10: begin a = 1; alu = 3'd1; ps = 2'd1; dn = 1;
                      pw = (o == 6'b000100 && z) || (o == 6'b000111 && g); end
         4'd11: begin pw = 1; dn = 1; ps = (o == 6'd0) ? 2'd3 : 2'd2;
                      if (o == 6'b000011) begin rw = 1; rd = 2'd2; wb = 2'd2; end end
         4'd12: er = 1;
         default: ;
      endcase
      return {pw, ps, irw, rw, rd, wb, a, b, ext, alu, mw, dn, er, st};
   endfunction

   always @(negedge clk) begin
      #2;
      if (exp_valid) begin
         check("cycle", 32'(act), 32'(exp_vec));
         obs_cycles++;
         if (act[6])  obs_mem++;
         if (act[18]) begin obs_reg++; obs_reg_cycle = obs_cycles; end
         if (act[5])  obs_done++;
         if (act[22]) obs_pcwr++;
      end
   end

   logic [3:0] seq[$];
   bit         lst[$];

   task automatic push_n(input logic [3:0] st, input int n);
      for (int i = 0; i < n; i++) begin
         seq.push_back(st);
         lst.push_back(i == n - 1);
      end
   endtask

   // Called at posedge+1 of an S_IF cycle; returns at posedge+1 after the last cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int mw,
                            input bit fix, input bit fz, input bit fg);
      seq.delete(); lst.delete();
      push_n(S_IF, 1); push_n(S_ID, 1);
      if (o == 6'd0) begin
         if (f == 6'b001000) push_n(S_JMP, 1);
         else if (f == 6'b100001 || f == 6'b100011 || f == 6'b101010) begin
            push_n(S_EXE_R, 1); push_n(S_WB_R, 1);
         end else push_n(S_ERR, 20);
      end else if (o == 6'b000010 || o == 6'b000011) push_n(S_JMP, 1);
      else if (o == 6'b001001 || o == 6'b001101 || o == 6'b001111) begin
         push_n(S_EXE_I, 1); push_n(S_WB_I, 1);
      end else if (o == 6'b100011) begin
         push_n(S_ADDR, 1); push_n(S_MEM_LD, mw + 1); push_n(S_WB_LD, 1);
      end else if (o == 6'b101011) begin
         push_n(S_ADDR, 1); push_n(S_MEM_ST, mw + 1);
      end else if (o == 6'b000100 || o == 6'b000111) push_n(S_BR, 1);
      else push_n(S_ERR, 20);

      {obs_cycles, obs_mem, obs_reg, obs_reg_cycle, obs_done, obs_pcwr} = '0;
      op = o; funct = f;
      for (int k = 0; k < seq.size(); k++) begin
         zero = fix ? fz : 1'($urandom_range(0, 1));
         gtz  = fix ? fg : 1'($urandom_range(0, 1));
         exp_vec   = model(seq[k], o, f, zero, gtz, lst[k]);
         exp_valid = 1'b1;
         @(posedge clk); #1;
      end
      exp_valid = 1'b0;
   endtask

   logic [5:0] ops [13] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'b001001, 6'b001101, 6'b001111,
                            6'b100011, 6'b101011, 6'b000100, 6'b000111, 6'b000010, 6'b000011};
   logic [5:0] fns [4]  = '{6'b100001, 6'b100011, 6'b101010, 6'b001000};

   task automatic run_random(input int n, input int mw);
      int idx;
      logic [5:0] f;
      for (int i = 0; i < n; i++) begin
         idx = $urandom_range(0, 12);
         f = (idx < 4) ? fns[idx] : 6'($urandom);
         run_instr(ops[idx], f, mw, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst0 = 1; rst1 = 1; sel = 0; op = '0; funct = '0; zero = 0; gtz = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state0", 32'(v0[3:0]), 32'(S_IF));
      check("reset_we0", 32'({v0[22], v0[19], v0[18], v0[6], v0[5], v0[4]}), 32'd0);
      check("reset_we1", 32'({v1[22], v1[19], v1[18], v1[6], v1[5], v1[4]}), 32'd0);
      rst0 = 0;

      run_instr(OP_LW, 6'd0, 0, 1'b1, 1'b0, 1'b0);
      check("lw_cycles", obs_cycles, 5);
      check("lw_reg_once", obs_reg, 1);
      check("lw_reg_cycle", obs_reg_cycle, 5);
      check("lw_done", obs_done, 1);

      run_instr(OP_BGTZ, 6'd0, 0, 1'b1, 1'b0, 1'b1);
      check("bgtz_taken_cycles", obs_cycles, 3);
      check("bgtz_taken_pcwr", obs_pcwr, 2);
      run_instr(OP_BGTZ, 6'd0, 0, 1'b1, 1'b1, 1'b0);
      check("bgtz_nt_cycles", obs_cycles, 3);
      check("bgtz_nt_pcwr", obs_pcwr, 1);

      run_instr(OP_JAL, 6'd0, 0, 1'b0, 1'b0, 1'b0);
      check("jal_cycles", obs_cycles, 3);
      run_instr(OP_RTYPE, FN_JR, 0, 1'b0, 1'b0, 1'b0);
      check("jr_reg_wr", obs_reg, 0);

      run_random(60, 0);

      run_instr(6'b111111, 6'($urandom), 0, 1'b0, 1'b0, 1'b0);
      check("err_no_writes", obs_mem + obs_reg + obs_done + obs_pcwr, 1);
      @(negedge clk); #3; rst0 = 1; #1;
      check("err_reset_state", 32'(v0[3:0]), 32'(S_IF));
      check("err_reset_err", 32'(v0[4]), 32'd0);
      @(posedge clk); #1; rst0 = 0;
      run_instr(OP_RTYPE, FN_ADDU, 0, 1'b0, 1'b0, 1'b0);
      check("post_err_cycles", obs_cycles, 4);

      rst0 = 1; sel = 1;
      @(posedge clk); #1; rst1 = 0;
      run_instr(OP_SW, 6'd0, 3, 1'b0, 1'b0, 1'b0);
      check("sw3_cycles", obs_cycles, 7);
      check("sw3_mem_wr", obs_mem, 4);
      check("sw3_done", obs_done, 1);

      op = OP_SW; funct = '0;
      repeat (4) @(posedge clk);
      #2;
      check("mid_st_state", 32'(v1[3:0]), 32'(S_MEM_ST));
      check("mid_st_mem_wr", 32'(v1[6]), 32'd1);
      rst1 = 1; #1;
      check("mid_rst_mem_wr", 32'(v1[6]), 32'd0);
      check("mid_rst_state", 32'(v1[3:0]), 32'(S_IF));
      @(posedge clk); #1; rst1 = 0;
      run_instr(OP_SW, 6'd0, 3, 1'b0, 1'b0, 1'b0);
      check("post_rst_sw_mem_wr", obs_mem, 4);

      run_random(30, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control-unit FSM that sequences the multi-cycle MIPS datapath.
- Decodes the latched IR opcode/funct and steps each instruction through IF/ID/EXE/MEM/WB.
- Emits per-cycle mux selects, ALU op and register/memory/PC write enables.
- Sits beside the datapath inside the CPU top; the top exposes only clk and reset.

Parameters:
- MEM_WAIT, 0, extra wait cycles held in each data-memory state (0..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces state to S_IF.
- op  in  6  IR[31:26]; valid from the ID cycle onward.
- funct  in  6  IR[5:0]; valid from the ID cycle onward.
- zero  in  1  ALU result == 0.
- gtz  in  1  signed rs > 0, from the datapath.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 {PC[31:28],IR[25:0],00}, 11 rs.
- ir_wr  out  1  IR write enable.
- reg_wr  out  1  register-file write enable.
- reg_dst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- wb_src  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  ALU operand A: 0 PC, 1 rs.
- alu_src_b  out  2  ALU operand B: 00 rt, 01 const 4, 10 ext(imm), 11 ext(imm)<<2.
- ext_op  out  1  immediate extend: 0 zero-extend, 1 sign-extend.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 slt, 100 lui (B<<16).
- mem_wr  out  1  data-memory write enable.
- instr_done  out  1  one-cycle pulse in an instruction's final cycle.
- err  out  1  high while in S_ERR.
- state  out  4  current state, for debug.

Behaviour:
- Supported instructions:
  - R-type: addu 100001, subu 100011, slt 101010, jr 001000.
  - I-type: addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011.
  - Branch/jump: beq 000100, bgtz 000111, j 000010, jal 000011.
- Output style: Moore; all outputs decode from the state register, op and funct only. zero/gtz affect pc_wr in S_BR only.
- Reset: state=S_IF and wcnt=0 asynchronously. While reset=1, every write enable, instr_done and err is forced to 0. Asserting reset mid-instruction discards that instruction.
- Default outputs: every output not listed for a state is 0.
- S_IF: ir_wr=1, pc_wr=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=add. Next state S_ID.
- S_ID: alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=add (precomputes branch target into ALUOut). Next state by op:
  - R-type jr or j/jal -> S_JMP.
  - Other R-type funct in the supported set -> S_EXE_R.
  - addiu/ori/lui -> S_EXE_I.
  - lw/sw -> S_ADDR.
  - beq/bgtz -> S_BR.
  - anything else -> S_ERR.
- S_EXE_R: alu_src_a=1, alu_src_b=00, alu_op from funct. Next state S_WB_R.
- S_WB_R: reg_wr=1, reg_dst=01, wb_src=00, instr_done=1. Next state S_IF.
- S_EXE_I: alu_src_a=1, alu_src_b=10; ext_op=1 for addiu, 0 otherwise; alu_op add/or/lui. Next state S_WB_I.
- S_WB_I: reg_wr=1, reg_dst=00, wb_src=00, instr_done=1. Next state S_IF.
- S_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=add. Next state S_MEM_LD (lw) or S_MEM_ST (sw).
- Memory states (S_MEM_LD, S_MEM_ST) hold for MEM_WAIT+1 cycles:
  - wcnt increments each cycle; the state exits when wcnt==MEM_WAIT, and wcnt clears on exit.
  - S_MEM_ST: mem_wr=1 in every cycle of the state; instr_done=1 in the last cycle. Next state S_IF.
  - S_MEM_LD: next state S_WB_LD.
- S_WB_LD: reg_wr=1, reg_dst=00, wb_src=01, instr_done=1. Next state S_IF.
- S_BR: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, instr_done=1.
  - pc_wr = (beq & zero) | (bgtz & gtz).
  - Next state S_IF.
- S_JMP: pc_wr=1, instr_done=1. Next state S_IF.
  - jr: pc_src=11.
  - j/jal: pc_src=10.
  - jal additionally: reg_wr=1, reg_dst=10, wb_src=10 (PC already holds PC+4).
- S_ERR: err=1, all write enables 0; holds until reset.
- Cycle counts with MEM_WAIT=0: branch/jump 3, R-type/I-type 4, sw 4, lw 5. Each memory state adds MEM_WAIT cycles.

Decomposition:
- Shared package mips_defs holds:
  - opcode and funct localparams;
  - the ALU_ADD..ALU_LUI codes;
  - pc_src, reg_dst, wb_src and alu_src_b select encodings;
  - the 4-bit state encodings S_IF..S_ERR.
- One natural sub-module: multicycle_ctrl_dec, a combinational state+op+funct -> control-vector decoder. The FSM register, wcnt and next-state logic stay in multicycle_ctrl.

Test Plan:
- Reset then op=100011 (lw), MEM_WAIT=0 -> states IF,ID,ADDR,MEM_LD,WB_LD; reg_wr only in cycle 5 with wb_src=01; instr_done pulses once.
- op=000111 (bgtz) with gtz=1, then gtz=0 -> S_BR pc_wr=1 pc_src=01, then pc_wr=0; both take 3 cycles.
- MEM_WAIT=3, op=101011 (sw) -> mem_wr high exactly 4 consecutive cycles; instr_done in the 4th; total 7 cycles.
- op=000011 (jal) -> S_JMP: pc_wr=1, pc_src=10, reg_wr=1, reg_dst=10, wb_src=10. op=0/funct=001000 (jr) -> pc_src=11, reg_wr=0.
- op=111111 -> S_ERR: err=1, no writes for 20 cycles. reset pulse -> S_IF, err=0.
- reset asserted mid-S_MEM_ST (async, between edges) -> mem_wr drops to 0 immediately; state=S_IF; wcnt=0.
